// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clock-enable divider controller.
package clk_div_pkg;

    localparam int unsigned DIV_DEFAULT_1MHZ = 50;
    localparam int unsigned DIV_MAX_W        = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STOP  = 2'd2,
        BURST = 2'd3
    } state_e;

    // A divisor of zero would never reach terminal count; treat it as one.
    function automatic logic [DIV_MAX_W-1:0] clamp_div(input logic [DIV_MAX_W-1:0] d);
        return (d == '0) ? DIV_MAX_W'(1) : d;
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// Divide counter, terminal detect, clk_out toggle and boundary-aligned divisor swap.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DIV_DEFAULT = DIV_DEFAULT_1MHZ
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_xfer,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             term_c,
    output logic             tick,
    output logic             clk_out,
    output logic             cfg_ready
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] div_pend;
    logic [WIDTH-1:0] div_in;
    logic             pend_v;

    assign div_in = WIDTH'(clamp_div(DIV_MAX_W'(cfg_div)));
    assign term_c = en && (cnt == div_act - WIDTH'(1));

    // While idle a new divisor is used directly; otherwise it waits for the next boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            div_act   <= WIDTH'(DIV_DEFAULT);
            div_pend  <= '0;
            pend_v    <= 1'b0;
            tick      <= 1'b0;
            clk_out   <= 1'b0;
            cfg_ready <= 1'b1;
        end else begin
            tick <= term_c;
            if (!en || term_c) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + WIDTH'(1);
            end
            if (term_c) begin
                clk_out <= !clk_out;
            end
            if (cfg_xfer && !en) begin
                div_act <= div_in;
            end else if (term_c && pend_v) begin
                div_act <= div_pend;
            end
            if (cfg_xfer && en) begin
                div_pend  <= div_in;
                pend_v    <= 1'b1;
                cfg_ready <= 1'b0;
            end else if (term_c) begin
                pend_v    <= 1'b0;
                cfg_ready <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Mode sequencer (idle/run/stop/burst) and divisor handshake around clk_div_core.
// Optional input synchronizers: define CLK_DIV_CTRL_SYNC_EN.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DIV_DEFAULT = DIV_DEFAULT_1MHZ,
    parameter int unsigned BURST_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    input  logic [WIDTH-1:0]   cfg_div,
    output logic               cfg_ready,
    input  logic               run,
    input  logic               burst_start,
    input  logic [BURST_W-1:0] burst_len,
    output logic               tick,
    output logic               clk_out,
    output logic               busy,
    output logic               burst_done
);

    state_e             state;
    state_e             state_d;
    logic [BURST_W-1:0] remain;
    logic [BURST_W-1:0] remain_d;
    logic               burst_done_d;
    logic               busy_d;
    logic               run_i;
    logic               burst_go;
    logic               term_c;
    logic               cfg_xfer;
    logic               en_c;

`ifdef CLK_DIV_CTRL_SYNC_EN
    logic [1:0] run_sync;
    logic [2:0] bs_sync;

    // Two-flop synchronizers; the third burst flop provides the rising-edge detect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_sync <= '0;
            bs_sync  <= '0;
        end else begin
            run_sync <= {run_sync[0], run};
            bs_sync  <= {bs_sync[1:0], burst_start};
        end
    end

    assign run_i    = run_sync[1];
    assign burst_go = bs_sync[1] && !bs_sync[2];
`else
    assign run_i    = run;
    assign burst_go = burst_start;
`endif

    assign cfg_xfer = cfg_valid && cfg_ready;
    assign en_c     = (state != IDLE);

    clk_div_core #(
        .WIDTH       (WIDTH),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .en        (en_c),
        .cfg_xfer  (cfg_xfer),
        .cfg_div   (cfg_div),
        .term_c    (term_c),
        .tick      (tick),
        .clk_out   (clk_out),
        .cfg_ready (cfg_ready)
    );

    // Every exit to IDLE happens at a boundary where clk_out falls.
    always_comb begin
        state_d      = state;
        remain_d     = remain;
        burst_done_d = 1'b0;
        case (state)
            IDLE: begin
                if (burst_go && (burst_len != '0)) begin
                    state_d  = BURST;
                    remain_d = burst_len;
                end else if (run_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!run_i) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (run_i) begin
                    state_d = RUN;
                end else if (term_c && clk_out) begin
                    state_d = IDLE;
                end
            end
            BURST: begin
                if (term_c) begin
                    remain_d = remain - BURST_W'(1);
                    if (remain == BURST_W'(1)) begin
                        burst_done_d = 1'b1;
                        state_d      = clk_out ? IDLE : STOP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            remain     <= '0;
            burst_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            remain     <= remain_d;
            burst_done <= burst_done_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed and random stimulus for clk_div_ctrl, compared against a countdown reference model.
module tb_clk_div_ctrl;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned BURST_W = 8;
    localparam int unsigned DIV_DEF = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               cfg_valid = 1'b0;
    logic [WIDTH-1:0]   cfg_div = '0;
    logic               cfg_ready;
    logic               run = 1'b0;
    logic               burst_start = 1'b0;
    logic [BURST_W-1:0] burst_len = '0;
    logic               tick;
    logic               clk_out;
    logic               busy;
    logic               burst_done;

    int errors = 0;
    int checks = 0;

    // Reference state: mode 0 idle, 1 run, 2 stop, 3 burst; left = cycles until next tick.
    int m_mode, m_left, m_div, m_pdiv, m_remain;
    bit m_pend, m_clk, m_tick, m_done;

    clk_div_ctrl #(
        .WIDTH       (WIDTH),
        .DIV_DEFAULT (DIV_DEF),
        .BURST_W     (BURST_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_div     (cfg_div),
        .cfg_ready   (cfg_ready),
        .run         (run),
        .burst_start (burst_start),
        .burst_len   (burst_len),
        .tick        (tick),
        .clk_out     (clk_out),
        .busy        (busy),
        .burst_done  (burst_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp1(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_div = DIV_DEF; m_left = DIV_DEF; m_pdiv = 0; m_remain = 0;
        m_pend = 0; m_clk = 0; m_tick = 0; m_done = 0;
    endtask

    // Advance the model across one clock edge using the inputs currently driven.
    task automatic model_step();
        bit hit, xfer;
        int nd, mode_n;
        hit    = (m_mode != 0) && (m_left == 1);
        xfer   = cfg_valid && !m_pend;
        nd     = m_div;
        mode_n = m_mode;
        m_done = 0;
        if (hit && m_pend) begin
            nd = m_pdiv;
            m_pend = 0;
        end
        if (xfer) begin
            if (m_mode == 0) nd = clamp1(int'(cfg_div));
            else begin
                m_pdiv = clamp1(int'(cfg_div));
                m_pend = 1;
            end
        end
        case (m_mode)
            0: if (burst_start && burst_len != 0) begin mode_n = 3; m_remain = int'(burst_len); end
               else if (run) mode_n = 1;
            1: if (!run) mode_n = 2;
            2: if (run) mode_n = 1; else if (hit && m_clk) mode_n = 0;
            default: if (hit) begin
                m_remain--;
                if (m_remain == 0) begin
                    m_done = 1;
                    mode_n = m_clk ? 0 : 2;
                end
            end
        endcase
        if (m_mode == 0 || hit) m_left = nd;
        else m_left--;
        m_div  = nd;
        m_tick = hit;
        if (hit) m_clk = !m_clk;
        m_mode = mode_n;
    endtask

    task automatic check_all();
        chk("tick", 32'(tick), 32'(m_tick));
        chk("clk_out", 32'(clk_out), 32'(m_clk));
        chk("busy", 32'(busy), 32'(m_mode != 0));
        chk("burst_done", 32'(burst_done), 32'(m_done));
        chk("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        burst_start = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_tick"}, 32'(tick), 0);
        chk({tag, "_clk_out"}, 32'(clk_out), 0);
        chk({tag, "_cfg_ready"}, 32'(cfg_ready), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_burst_done"}, 32'(burst_done), 0);
    endtask

    initial begin
        int nt;
        model_reset();
        #12;
        check_reset_values("reset");
        @(posedge clk); #1;
        reset = 1'b1;

        // Free run at the default divisor, then stop while clk_out is high.
        run = 1'b1;
        steps(20);
        for (int i = 0; i < 20 && !m_clk; i++) step();
        chk("clk_hi_before_stop", 32'(clk_out), 1);
        run = 1'b0;
        steps(12);
        chk("stop_idle", 32'(busy), 0);

        // Divisor change while running; a second offer inside the pending window must wait.
        run = 1'b1;
        steps(6);
        cfg_valid = 1'b1; cfg_div = 2;
        step();
        cfg_div = 3;
        step();
        cfg_valid = 1'b0;
        steps(12);
        run = 1'b0;
        steps(14);

        // Burst of 3 at div 1: three burst ticks plus one stop tick.
        cfg_valid = 1'b1; cfg_div = 1;
        step();
        cfg_valid = 1'b0;
        burst_start = 1'b1; burst_len = 3;
        step();
        nt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (tick) nt++;
        end
        chk("burst_ticks", 32'(nt), 4);
        chk("burst_end_clk", 32'(clk_out), 0);

        // Ignored burst requests: zero length, and while running.
        burst_start = 1'b1; burst_len = 0;
        step();
        chk("zero_len_idle", 32'(busy), 0);
        run = 1'b1;
        steps(3);
        burst_start = 1'b1; burst_len = 2;
        steps(6);
        run = 1'b0;
        steps(10);

        // Zero divisor clamps to one: tick every cycle.
        cfg_valid = 1'b1; cfg_div = 0;
        step();
        cfg_valid = 1'b0; run = 1'b1;
        steps(8);
        run = 1'b0;
        steps(6);

        // Reset during a burst with a divisor pending.
        cfg_valid = 1'b1; cfg_div = 3;
        step();
        cfg_valid = 1'b0;
        burst_start = 1'b1; burst_len = 5;
        steps(4);
        cfg_valid = 1'b1; cfg_div = 2;
        step();
        cfg_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        run = 1'b1;
        steps(14);
        run = 1'b0;
        steps(12);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) run = !run;
            cfg_valid   = ($urandom_range(0, 7) == 0);
            cfg_div     = WIDTH'($urandom_range(0, 5));
            burst_start = ($urandom_range(0, 15) == 0);
            burst_len   = BURST_W'($urandom_range(0, 4));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Runtime-programmable controller for the calculator's clock-enable generation. It owns the divide counter and sequences it through idle, free-run, counted-burst and graceful-stop modes. Divisor changes arrive through a valid/ready handshake and are applied only at a period boundary, so the output never glitches. Consumers such as display multiplexing, keypad scan and debounce take the `tick` enable or the divided `clk_out`; none of them runs a free counter of its own.

## Interface
- `WIDTH`, 32: divide counter and divisor width.
- `DIV_DEFAULT`, 50: divisor loaded at reset (1 MHz half-period from 50 MHz; half-period = div cycles).
- `BURST_W`, 8: burst length width.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  one clock; reset is asynchronous and active-low.
- `cfg_valid`  in  1  new divisor offered.
- `cfg_div`  in  WIDTH  divisor value; 0 is clamped to 1.
- `cfg_ready`  out  1  controller can accept a divisor.
- `run`  in  1  level request for free-running output.
- `burst_start`  in  1  single-cycle request for a counted burst.
- `burst_len`  in  BURST_W  number of ticks in the burst; 0 is ignored.
- `tick`  out  1  one-cycle enable at each half-period boundary.
- `clk_out`  out  1  toggles on every tick; 50 % duty.
- `busy`  out  1  state is not IDLE.
- `burst_done`  out  1  one-cycle pulse coincident with the last burst tick.

## Operation
- Registers: `state`, `cnt` (WIDTH), `div_act`, `div_pend`, `pend_v`, `remain` (BURST_W), `clk_out`.
- Terminal count is `cnt == div_act-1`. At terminal count: `tick`=1, `clk_out` toggles, `cnt`←0; if `pend_v`, then `div_act`←`div_pend` and `pend_v`←0. Otherwise `cnt` increments. The counter holds at 0 in IDLE.
- Config handshake: a transfer occurs when `cfg_valid`&`cfg_ready`.
  - In IDLE the value goes straight to `div_act`.
  - Otherwise it goes to `div_pend` and `pend_v`←1.
  - `cfg_ready` = !`pend_v`.
- States:
  - IDLE→BURST: `burst_start`&&`burst_len`!=0. This has priority over `run`. Loads `remain`←`burst_len`.
  - IDLE→RUN: `run`.
  - RUN→STOP: !`run`.
  - STOP→RUN: `run`.
  - STOP→IDLE: at a terminal count where `clk_out` toggles to 0.
  - BURST: each tick decrements `remain`. The last tick pulses `burst_done`. Next state is IDLE if `clk_out` becomes 0, else STOP.
  - `burst_start` outside IDLE is ignored. `run` is ignored during BURST.
- STOP keeps emitting ticks until `clk_out` is low. Every stop therefore leaves `clk_out`=0.
- Simultaneous events:
  - cfg transfer plus terminal count in a non-IDLE state: the new value goes to `div_pend` and applies at the next boundary.
  - Reset mid-operation aborts immediately, and any pending divisor is lost.

## Timing
- Reset values:
  - Outputs: `tick`=0, `clk_out`=0, `cfg_ready`=1, `busy`=0, `burst_done`=0.
  - Internal: `div_act`=DIV_DEFAULT, IDLE.
- All outputs are registered.
- If `run` is sampled high at edge k, the first `tick` is high in the cycle after edge k+div_act.
- After that, `tick` repeats every div_act cycles, and the `clk_out` period is 2·div_act.
- With div_act=1, `tick` is high continuously and `clk_out` toggles every cycle.
- Divisor latency:
  - In IDLE, the new value is used by the next start.
  - Otherwise it takes effect for the period starting after the next tick; `cfg_ready` returns high on that same edge.
- `busy` falls on the edge that enters IDLE.

## Configuration
- `CLK_DIV_CTRL_SYNC_EN`:
  - Defined: `run` and `burst_start` pass through 2-flop synchronizers reset to 0. `burst_start` is edge-detected after synchronization. All start/stop latencies grow by 2 cycles.
  - Undefined: inputs are used directly and must be synchronous to `clk`.

## Structure
- Shared package `clk_div_pkg`:
  - State enum `IDLE`/`RUN`/`STOP`/`BURST`.
  - `DIV_DEFAULT_1MHZ`=50.
  - Clamp-to-1 function for divisor.
- Natural sub-module: `clk_div_core`, holding the counter, terminal detect, `clk_out` toggle and pending-divisor swap. `clk_div_ctrl` holds the FSM, burst counter and handshake.

## Test plan
- After reset with DIV_DEFAULT=4, raise `run`: `tick` every 4 cycles, `clk_out` period 8. Drop `run` while `clk_out`=1: one more tick, then `clk_out`=0, `busy`=0.
- Running at div 4, offer `cfg_div`=2: `cfg_ready` low until next tick. Subsequent ticks come every 2 cycles. A second offer during the pending window is not accepted.
- IDLE at div 1, `burst_len`=3: exactly 3 burst ticks with `burst_done` on the third, then one STOP tick. `clk_out` ends at 0, and 4 ticks total.
- `burst_start` with `burst_len`=0, and `burst_start` during RUN: no state change, no `burst_done`.
- `cfg_div`=0 in IDLE, then `run`: `tick` high every cycle.
- Assert `reset` mid-burst with a pending divisor: all outputs go to reset values asynchronously. On restart, `div_act`=DIV_DEFAULT.
